// File: rtl/router_flit_injector.sv
// Local-port flit transmitter: turns descriptors plus payload words into head/body/tail
// flits, gated by credits returned from the router input buffer.
//   state  | meaning
//   S_IDLE | waiting for a packet descriptor
//   S_HEAD | descriptor latched, head flit goes out once a credit is available
//   S_BODY | forwarding payload words, one per credit
module router_flit_injector #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 3,
  parameter int LEN_W   = 4,
  parameter int CREDITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [COORD_W-1:0]  pkt_dst_x,
  input  logic [COORD_W-1:0]  pkt_dst_y,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic                pay_valid,
  output logic                pay_ready,
  input  logic [DATA_W-1:0]   pay_data,
  output logic                flit_valid,
  output logic [1:0]          flit_type,
  output logic [DATA_W-1:0]   flit_data,
  input  logic                credit_in,
  output logic [LEN_W:0]      credit_cnt,
  output logic                busy,
  output logic                err_credit
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HEAD = 2'd1, S_BODY = 2'd2} state_t;

  localparam logic [LEN_W:0]   CRED_MAX = (LEN_W+1)'(CREDITS);
  localparam logic [LEN_W:0]   CRED_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [LEN_W-1:0]    len_q, len_d, rem_q, rem_d;
  logic                flit_valid_q, flit_valid_d;
  logic [1:0]          flit_type_q, flit_type_d;
  logic [DATA_W-1:0]   flit_data_q, flit_data_d;
  logic [LEN_W:0]      credit_q, credit_d;
  logic                err_q, err_d;
  logic                can_send, pay_hs, load;

  assign can_send  = (credit_q != '0);
  assign pkt_ready = (state_q == S_IDLE);
  assign pay_ready = (state_q == S_BODY) && can_send;
  assign pay_hs    = pay_valid && pay_ready;
  assign load      = ((state_q == S_HEAD) && can_send) || pay_hs;

  always_comb begin
    state_d      = state_q;
    dst_x_d      = dst_x_q;
    dst_y_d      = dst_y_q;
    len_d        = len_q;
    rem_d        = rem_q;
    flit_valid_d = 1'b0;
    flit_type_d  = flit_type_q;
    flit_data_d  = flit_data_q;
    credit_d     = credit_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          dst_x_d = pkt_dst_x;
          dst_y_d = pkt_dst_y;
          len_d   = pkt_len;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (can_send) begin
          flit_valid_d = 1'b1;
          flit_data_d  = DATA_W'({dst_y_q, dst_x_q, len_q});
          if (len_q == '0) begin
            flit_type_d = 2'b11;
            state_d     = S_IDLE;
          end else begin
            flit_type_d = 2'b01;
            rem_d       = len_q;
            state_d     = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (pay_hs) begin
          flit_valid_d = 1'b1;
          flit_data_d  = pay_data;
          rem_d        = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            flit_type_d = 2'b10;
            state_d     = S_IDLE;
          end else begin
            flit_type_d = 2'b00;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A send and a returned credit in the same cycle cancel out.
    if (load && !credit_in) begin
      credit_d = credit_q - CRED_ONE;
    end else if (!load && credit_in) begin
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else                      credit_d = credit_q + CRED_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_type_q  <= 2'b00;
      flit_data_q  <= '0;
      credit_q     <= CRED_MAX;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dst_x_q      <= dst_x_d;
      dst_y_q      <= dst_y_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      flit_valid_q <= flit_valid_d;
      flit_type_q  <= flit_type_d;
      flit_data_q  <= flit_data_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
    end
  end

  assign flit_valid = flit_valid_q;
  assign flit_type  = flit_type_q;
  assign flit_data  = flit_data_q;
  assign credit_cnt = credit_q;
  assign busy       = (state_q != S_IDLE);
  assign err_credit = err_q;

endmodule

// File: tb/tb_router_flit_injector.sv
// Bench for router_flit_injector: fixed vector table, hand-built stall/reset/credit
// sequences, and random packets checked against a flit-queue and credit-ledger model.
module tb_router_flit_injector;
  localparam int DATA_W = 32, COORD_W = 3, LEN_W = 4, CREDITS = 4;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               pkt_valid = 1'b0, pkt_ready;
  logic [COORD_W-1:0] pkt_dst_x = '0, pkt_dst_y = '0;
  logic [LEN_W-1:0]   pkt_len = '0;
  logic               pay_valid = 1'b0, pay_ready;
  logic [DATA_W-1:0]  pay_data = '0;
  logic               flit_valid;
  logic [1:0]         flit_type;
  logic [DATA_W-1:0]  flit_data;
  logic               credit_in = 1'b0;
  logic [LEN_W:0]     credit_cnt;
  logic               busy, err_credit;

  router_flit_injector #(.DATA_W(DATA_W), .COORD_W(COORD_W), .LEN_W(LEN_W), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dst_x(pkt_dst_x), .pkt_dst_y(pkt_dst_y), .pkt_len(pkt_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .flit_valid(flit_valid), .flit_type(flit_type), .flit_data(flit_data),
    .credit_in(credit_in), .credit_cnt(credit_cnt), .busy(busy), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] t; logic [31:0] d; } flit_t;
  typedef struct {
    int x, y, len;
    logic [1:0] head_t; logic [31:0] head_d; logic [1:0] last_t;
    int nflits, cycles, cred;
  } vec_t;

  int    total = 0, bad = 0;
  flit_t exp_q[$];
  flit_t cap[$];
  int    outstanding = 0;
  int    model_rem = 0;
  vec_t  vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model after it.
  task automatic tick();
    logic pkt_hs, pay_hs, cred, rst_edge;
    logic [LEN_W-1:0] len_s;
    logic [COORD_W-1:0] x_s, y_s;
    logic [31:0] pd;
    @(negedge clk);
    pkt_hs = pkt_valid && pkt_ready;
    pay_hs = pay_valid && pay_ready;
    cred = credit_in; rst_edge = !rst_n;
    len_s = pkt_len; x_s = pkt_dst_x; y_s = pkt_dst_y; pd = pay_data;
    if (rst_n) chk("pay_ready_without_credit", pay_ready && (outstanding >= CREDITS), 1'b0);
    @(posedge clk); #1;
    if (rst_edge) begin
      exp_q.delete(); outstanding = 0; model_rem = 0;
    end else begin
      if (pkt_hs) begin
        flit_t h;
        h.t = (len_s == 0) ? 2'b11 : 2'b01;
        h.d = {22'b0, y_s, x_s, len_s};
        exp_q.push_back(h);
        model_rem = int'(len_s);
      end
      if (pay_hs) begin
        flit_t b;
        b.t = (model_rem == 1) ? 2'b10 : 2'b00;
        b.d = pd;
        exp_q.push_back(b);
        model_rem--;
      end
      if (flit_valid) begin
        flit_t o;
        o.t = flit_type; o.d = flit_data;
        cap.push_back(o);
        outstanding++;
        if (exp_q.size() == 0) chk("unexpected_flit", 1'b1, 1'b0);
        else begin
          flit_t e;
          e = exp_q.pop_front();
          chk("flit_type", flit_type, e.t);
          chk("flit_data", flit_data, e.d);
        end
      end
      if (cred && outstanding > 0) outstanding--;
      chk("credit_over_limit", outstanding > CREDITS, 1'b0);
      if (pkt_hs) pkt_valid = 1'b0;
    end
    chk("credit_cnt", credit_cnt, CREDITS - outstanding);
    if (pay_hs) pay_data = $urandom();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pkt_valid = 1'b0; pay_valid = 1'b0; credit_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    cap.delete();
  endtask

  task automatic run_pkt(input int x, input int y, input int len, input int pay_pct,
                         input int cred_pct, input int max_cyc, output int ncyc);
    cap.delete();
    pkt_dst_x = COORD_W'(x); pkt_dst_y = COORD_W'(y); pkt_len = LEN_W'(len);
    pkt_valid = 1'b1;
    ncyc = 0;
    while (cap.size() < len + 1 && ncyc < max_cyc) begin
      pay_valid = ($urandom_range(99) < pay_pct);
      credit_in = (outstanding > 0) && ($urandom_range(99) < cred_pct);
      tick();
      ncyc++;
    end
    pay_valid = 1'b0; credit_in = 1'b0; pkt_valid = 1'b0;
    if (ncyc >= max_cyc) chk("packet_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{3, 5, 0, 2'b11, 32'h2B0, 2'b11, 1, 2, 3};
    vecs[1] = '{0, 0, 0, 2'b11, 32'h000, 2'b11, 1, 2, 3};
    vecs[2] = '{7, 7, 0, 2'b11, 32'h3F0, 2'b11, 1, 2, 3};
    vecs[3] = '{1, 2, 3, 2'b01, 32'h113, 2'b10, 4, 5, 0};
    vecs[4] = '{6, 1, 1, 2'b01, 32'h0E1, 2'b10, 2, 3, 2};
    vecs[5] = '{2, 4, 2, 2'b01, 32'h222, 2'b10, 3, 4, 1};
    pay_data = $urandom();

    do_reset();
    chk("rst_flit_valid", flit_valid, 1'b0);
    chk("rst_flit_type", flit_type, 2'b00);
    chk("rst_flit_data", flit_data, 32'h0);
    chk("rst_credit_cnt", credit_cnt, CREDITS);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_credit", err_credit, 1'b0);
    chk("rst_pkt_ready", pkt_ready, 1'b1);
    chk("rst_pay_ready", pay_ready, 1'b0);

    // Vector table: full payload supply, no credits returned.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_pkt(vecs[i].x, vecs[i].y, vecs[i].len, 100, 0, 30, n);
      chk("vec_nflits", cap.size(), vecs[i].nflits);
      chk("vec_cycles", n, vecs[i].cycles);
      if (cap.size() > 0) begin
        chk("vec_head_type", cap[0].t, vecs[i].head_t);
        chk("vec_head_data", cap[0].d, vecs[i].head_d);
        chk("vec_last_type", cap[cap.size()-1].t, vecs[i].last_t);
      end
      chk("vec_credit", credit_cnt, vecs[i].cred);
      chk("vec_idle", busy, 1'b0);
    end

    // Credit starvation: stall after four flits, two returned credits finish the packet.
    do_reset();
    pkt_dst_x = 3'd1; pkt_dst_y = 3'd1; pkt_len = 4'd5; pkt_valid = 1'b1;
    pay_valid = 1'b1; credit_in = 1'b0;
    repeat (10) tick();
    chk("stall_nflits", cap.size(), 4);
    chk("stall_pay_ready", pay_ready, 1'b0);
    chk("stall_busy", busy, 1'b1);
    chk("stall_credit", credit_cnt, 0);
    repeat (2) begin
      credit_in = 1'b1; tick(); credit_in = 1'b0;
      repeat (3) tick();
    end
    pay_valid = 1'b0;
    chk("resume_nflits", cap.size(), 6);
    if (cap.size() == 6) chk("resume_tail", cap[5].t, 2'b10);
    chk("resume_credit", credit_cnt, 0);
    chk("resume_idle", busy, 1'b0);

    // Credit overflow is sticky; send plus credit in one cycle leaves the count alone.
    do_reset();
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk("ovf_err", err_credit, 1'b1);
    chk("ovf_credit", credit_cnt, CREDITS);
    tick();
    chk("ovf_err_sticky", err_credit, 1'b1);
    run_pkt(0, 0, 0, 100, 0, 10, n);
    chk("pre_simul_credit", credit_cnt, CREDITS - 1);
    cap.delete();
    pkt_dst_x = 3'd4; pkt_dst_y = 3'd2; pkt_len = 4'd0; pkt_valid = 1'b1;
    tick();
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    chk("simul_flit_valid", flit_valid, 1'b1);
    chk("simul_credit", credit_cnt, CREDITS - 1);
    tick();
    chk("simul_valid_drop", flit_valid, 1'b0);

    // Reset in the middle of a packet abandons it.
    do_reset();
    pkt_dst_x = 3'd5; pkt_dst_y = 3'd6; pkt_len = 4'd5; pkt_valid = 1'b1;
    pay_valid = 1'b1;
    n = 0;
    while (cap.size() < 3 && n < 20) begin tick(); n++; end
    chk("midrst_reach", cap.size(), 3);
    rst_n = 1'b0; pay_valid = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_flit_valid", flit_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_credit", credit_cnt, CREDITS);
    run_pkt(2, 3, 1, 100, 0, 20, n);
    chk("post_rst_nflits", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("post_rst_head", cap[0].t, 2'b01);
      chk("post_rst_tail", cap[1].t, 2'b10);
    end

    // Random packets with random payload gaps and credit returns.
    do_reset();
    for (int p = 0; p < 50; p++) begin
      run_pkt($urandom_range(7), $urandom_range(7), $urandom_range(15), 50, 50, 400, n);
    end
    chk("rand_queue_empty", exp_q.size(), 0);
    n = 0;
    while (outstanding > 0 && n < 20) begin credit_in = 1'b1; tick(); n++; end
    credit_in = 1'b0;
    tick();
    chk("rand_final_credit", credit_cnt, CREDITS);
    chk("rand_no_err", err_credit, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
